// File: rtl/lfsr_shuffle_engine.sv
// In-place swap shuffle of RAM entries 0..len_1 driven by a Galois LFSR.
// Unscramble walks the indices in reverse and steps the LFSR backward, exactly undoing a scramble.
module lfsr_shuffle_engine #(
   parameter int unsigned          DW     = 8,
   parameter int unsigned          AW     = 5,
   parameter int unsigned          LFSR_W = 16,
   parameter logic [LFSR_W-1:0]    TAPS   = 16'hB400,
   parameter logic [LFSR_W-1:0]    SEED   = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [AW-1:0]     len_1,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
   output logic              busy,
   output logic              done,
   output logic [LFSR_W-1:0] lfsr_state,
   output logic [AW-1:0]     r_addr,
   input  logic [DW-1:0]     dout,
   output logic [AW-1:0]     w_addr,
   output logic [DW-1:0]     din,
   output logic              we
);

   typedef enum logic [2:0] {IDLE, GEN, RDI, RDJ, WRI, WRJ, DONE} state_t;

   state_t            state;
   logic [AW-1:0]     i;
   logic [AW-1:0]     j;
   logic [AW-1:0]     len_q;
   logic              mode_q;
   logic [DW-1:0]     temp;
   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] lfsr_fwd;
   logic [AW-1:0]     last_i;

   function automatic logic [LFSR_W-1:0] fwd(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : '0);
   endfunction

   function automatic logic [LFSR_W-1:0] bwd(input logic [LFSR_W-1:0] n);
      return n[LFSR_W-1] ? (((n ^ TAPS) << 1) | LFSR_W'(1)) : (n << 1);
   endfunction

   function automatic logic [AW-1:0] smear(input logic [AW-1:0] v);
      logic [AW-1:0] m;
      m = v;
      for (int unsigned k = 1; k < AW; k++)
         m = m | (m >> k);
      return m;
   endfunction

   // Masking to the smeared limit leaves r <= 2*len_1+1, so one subtraction folds it into range.
   function automatic logic [AW-1:0] map_idx(input logic [LFSR_W-1:0] s, input logic [AW-1:0] lim);
      logic [AW-1:0] r;
      r = s[AW-1:0] & smear(lim);
      if (r > lim)
         r = r - (lim + AW'(1));
      return r;
   endfunction

   assign lfsr_fwd   = fwd(lfsr);
   assign last_i     = mode_q ? '0 : len_q;
   assign lfsr_state = lfsr;
   assign r_addr     = (state == RDJ) ? j : i;
   assign w_addr     = (state == WRJ) ? j : i;
   assign din        = (state == WRI) ? dout : temp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         i      <= '0;
         j      <= '0;
         len_q  <= '0;
         mode_q <= 1'b0;
         temp   <= '0;
         lfsr   <= SEED;
         busy   <= 1'b0;
         done   <= 1'b0;
         we     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (seed_load)
                  lfsr <= (seed == '0) ? SEED : seed;
               if (start) begin
                  mode_q <= mode;
                  len_q  <= len_1;
                  i      <= mode ? len_1 : '0;
                  busy   <= 1'b1;
                  state  <= GEN;
               end
            end
            GEN: begin
               if (!mode_q) begin
                  lfsr <= lfsr_fwd;
                  j    <= map_idx(lfsr_fwd, len_q);
               end else begin
                  j    <= map_idx(lfsr, len_q);
               end
               state <= RDI;
            end
            RDI: state <= RDJ;
            RDJ: begin
               temp  <= dout;
               we    <= 1'b1;
               state <= WRI;
            end
            WRI: state <= WRJ;
            WRJ: begin
               we <= 1'b0;
               if (mode_q)
                  lfsr <= bwd(lfsr);
               if (i == last_i) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  i     <= mode_q ? (i - AW'(1)) : (i + AW'(1));
                  state <= GEN;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/lfsr_shuffle_engine.md
# lfsr_shuffle_engine

Self-contained, parametrised memory shuffle engine for the LFSR scrambler path. It owns a Galois LFSR and a control FSM, and drives an external synchronous-read RAM to perform an in-place swap-based permutation of entries 0..len_1. The block adds what the earlier scrambler datapath lacked: its own sequencer, a start/done handshake, configurable widths, and an unscramble mode that exactly inverts a scramble by stepping the LFSR backward.

## Interface
Parameters:
- DW, 8, data word width
- AW, 5, address width; depth 2^AW
- LFSR_W, 16, LFSR width; must be ≥ AW
- TAPS, 16'hB400, Galois feedback mask; bit LFSR_W-1 must be 1
- SEED, 16'hACE1, reset and fallback LFSR state; nonzero

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- mode  in  1  0 = scramble, 1 = unscramble; sampled with start
- len_1  in  AW  last index to shuffle; sampled with start
- seed_load  in  1  load seed into the LFSR; honoured only in IDLE
- seed  in  LFSR_W  seed value; 0 loads SEED instead
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in the DONE state
- lfsr_state  out  LFSR_W  current LFSR register
- r_addr  out  AW  RAM read address
- dout  in  DW  RAM read data; valid one cycle after r_addr
- w_addr  out  AW  RAM write address
- din  out  DW  RAM write data
- we  out  1  RAM write enable

## Operation
- fwd(s) = (s>>1) ^ (s[0] ? TAPS : 0).
- bwd(n): if n[LFSR_W-1] is 1, then s = ((n^TAPS)<<1)|1; otherwise s = n<<1. bwd(fwd(s)) = s.
- map(s) = r & m, where r = s[AW-1:0] and m = OR-smear of len_1 (smallest all-ones value ≥ len_1). If the result exceeds len_1, subtract len_1+1. This guarantees j ≤ len_1.
- Scramble: for i = 0 up to len_1, set lfsr = fwd(lfsr), then j = map(new lfsr), then swap mem[i] and mem[j].
- Unscramble: for i = len_1 down to 0, set j = map(lfsr), swap mem[i] and mem[j], then lfsr = bwd(lfsr).
- A scramble followed by an unscramble with no reload restores the memory and returns the LFSR to its pre-scramble seed.
- FSM states: IDLE, GEN, RDI, RDJ, WRI, WRJ, DONE.
- IDLE: when start is high, latch mode and len_1, set i = 0 (scramble) or len_1 (unscramble), and go to GEN.
- GEN: scramble sets lfsr ← fwd(lfsr) and j ← map(fwd(lfsr)). Unscramble sets j ← map(lfsr).
- RDI: r_addr = i.
- RDJ: r_addr = j; temp ← dout (this is mem[i]).
- WRI: we = 1, w_addr = i, din = dout (this is mem[j]).
- WRJ: we = 1, w_addr = j, din = temp. In unscramble, lfsr ← bwd(lfsr). If i is the last index (len_1 for scramble, 0 for unscramble), go to DONE. Otherwise step i by ±1 and go to GEN.
- DONE: done = 1, then go to IDLE.
- Outside RDJ, r_addr = i. Outside WRJ, w_addr = i. Outside WRI, din = temp.
- When i = j, the full swap still executes and leaves memory unchanged.
- len_1 = 0 gives one pass; in scramble the LFSR still advances once.

## Timing
- Reset values: state IDLE, i = 0, j = 0, temp = 0, lfsr = SEED. Outputs: busy 0, done 0, we 0, r_addr 0, w_addr 0, din 0, lfsr_state SEED.
- Reset takes effect immediately and asynchronously, even mid-run. we drops at once and memory is left partially shuffled.
- Each element pass takes 5 cycles. If start is sampled at edge 0, busy is high from cycle 1 and done pulses in cycle 5·(len_1+1)+1. busy is high during DONE and low the cycle after.
- start is ignored while busy. seed_load is ignored while busy.
- If seed_load and start are both high in IDLE, the new seed is loaded and that run uses it.
- mode and len_1 changes during a run have no effect.
- RAM contract: a write in WRI/WRJ must be visible to a read issued on the next cycle.

## Test plan
- Reset, then scramble with SEED = 16'hACE1 and len_1 = 10. The first GEN gives lfsr = 16'hE270 and j = 0. done pulses in cycle 56 after the start edge.
- Fill RAM with 0..31, len_1 = 31, run a scramble then an unscramble. RAM must read 0..31 again and lfsr_state must equal 16'hACE1. Check that the scrambled image is a permutation (no duplicates).
- len_1 = 0, data 8'hAA at address 0: RAM unchanged, lfsr = 16'hE270, done pulses at cycle 6.
- Pulse start mid-run and seed_load with seed = 16'h1234: both ignored, total latency unchanged.
- seed_load with seed = 0: lfsr_state becomes 16'hACE1.
- Assert rst_n low during a WRI cycle: we, busy and done go to 0 immediately and lfsr returns to SEED. A following start runs normally.
